cla_serial_add_ctrl: RTL
========================

Name: cla_serial_add_ctrl

Overview:
Sequencer that performs a WIDTH-bit add or subtract by time-multiplexing one external 4-bit CLA slice, one nibble per cycle, LSB nibble first. It latches the operands on a start handshake and drives the slice's a/b/c_in each cycle. It captures the slice's s/c_out into a result register and a carry register, then reports sum, carry-out and signed overflow with a one-cycle done pulse. It sits between the execute-stage control and the shared cla_4b slice.

Parameters:
WIDTH  16  operand/result width in bits; must be a multiple of 4 and at least 4
NIB  WIDTH/4  number of nibble steps (derived; not overridden)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low (clears all state immediately when 0)
start  in  1  request; sampled only in IDLE
sub  in  1  1 = a - b, 0 = a + b + c_in; sampled with start
a  in  WIDTH  operand A; sampled with start
b  in  WIDTH  operand B; sampled with start
c_in  in  1  carry-in for add; ignored when sub=1
abort  in  1  cancel an operation in RUN
cla_a  out  4  nibble of A to slice
cla_b  out  4  nibble of effective B to slice
cla_cin  out  1  carry to slice
cla_s  in  4  slice sum
cla_cout  in  1  slice carry-out
busy  out  1  1 in RUN
done  out  1  one-cycle pulse, result valid
sum  out  WIDTH  result register
c_out  out  1  final carry (sub: 1 = no borrow)
ovf  out  1  two's-complement overflow

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, carry=0, a_reg=b_reg=0, sum=0, c_out=0, ovf=0, busy=0, done=0. cla_a, cla_b and cla_cin are 0.
- States: IDLE, RUN, DONE.
- IDLE with start=1:
  - a_reg<=a.
  - b_reg<=sub ? ~b : b.
  - carry<=sub ? 1 : c_in.
  - idx<=0.
  - Go to RUN.
  - sum, c_out and ovf keep their previous values until overwritten.
- IDLE with start=0: stay in IDLE.
- RUN outputs (combinational from registers):
  - cla_a=a_reg[4*idx+3:4*idx]
  - cla_b=b_reg[4*idx+3:4*idx]
  - cla_cin=carry
  - The slice is combinational; its result is consumed in the same cycle.
- RUN edge (abort=0):
  - sum[4*idx+3:4*idx]<=cla_s.
  - carry<=cla_cout.
  - idx<=idx+1.
- RUN, last nibble (idx==NIB-1), abort=0:
  - c_out<=cla_cout.
  - ovf<=a_reg[WIDTH-1]^b_reg[WIDTH-1]^cla_s[3]^cla_cout (carry into MSB XOR carry out).
  - Go to DONE.
- RUN with abort=1: go to IDLE. No nibble is written that cycle. done is not pulsed. sum holds partial contents and is undefined to consumers. abort outside RUN is ignored.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally. start in DONE is ignored and is not queued.
- busy=1 iff state==RUN. cla_* outputs are 0 in IDLE and DONE.
- Latency: start sampled at edge E0 -> RUN for NIB cycles -> done high in the cycle after edge E(NIB). For WIDTH=16, done is high 5 cycles after the start edge. Throughput is one op per NIB+2 cycles.
- start while busy is ignored; operands are not re-sampled.
- idx width is clog2(NIB), minimum 1 bit. idx resets to 0 on every accepted start, so no wrap occurs.
- Asserting rst mid-RUN clears everything; the operation is lost and no done pulse follows.
- sum, c_out and ovf are stable from DONE until the next completed operation.

Test Plan:
- Add carry-out: WIDTH=16, sub=0, a=0xFFFF, b=0x0001, c_in=0 -> done at start+5, sum=0x0000, c_out=1, ovf=0.
- Signed overflow: sub=0, a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1. Per-cycle cla_a is 0xF, 0xF, 0xF, 0x7 and cla_cin is 0, 1, 1, 1.
- Subtract with borrow: sub=1, a=0x0005, b=0x0007 (c_in=1, ignored) -> sum=0xFFFE, c_out=0, ovf=0.
- Subtract overflow: sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
- Ignored start: pulse start=1 with new operands during RUN and again in the DONE cycle -> no effect; busy high for exactly 4 cycles; a single done pulse; the original result is held.
- Abort and reset: abort=1 in the 2nd RUN cycle -> IDLE next cycle, no done. Then start an op and drive rst=0 mid-RUN -> all outputs 0 immediately. Release rst; a new op 0x1234+0x4321 -> 0x5555.

Source files
------------

// File: rtl/cla_serial_add_ctrl_if.sv
// Bundle between the execute-stage control / shared cla_4b slice and the serial add sequencer.
// Purely wiring; no latency of its own.
// No backpressure: start is a single-cycle request, done is a single-cycle pulse.
interface cla_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  // Request side
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             abort;

  // Shared 4-bit slice
  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic             cla_cin;
  logic [3:0]       cla_s;
  logic             cla_cout;

  // Result side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  // Environment side: issues requests and hosts the combinational slice
  modport master (
    output start, sub, a, b, c_in, abort, cla_s, cla_cout,
    input  cla_a, cla_b, cla_cin, busy, done, sum, c_out, ovf
  );

  // Sequencer side
  modport slave (
    input  start, sub, a, b, c_in, abort, cla_s, cla_cout,
    output cla_a, cla_b, cla_cin, busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit add/subtract by stepping one external 4-bit CLA slice over the operands, LSB nibble first.
// Latency: start edge -> NIB RUN cycles -> one-cycle done pulse; one op per NIB+2 cycles.
// No backpressure: start is only accepted in IDLE; requests in RUN/DONE are dropped, abort cancels RUN.
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_serial_add_ctrl_if.slave bus
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;

  // Select the operand nibbles addressed by the current step
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // Next-state: latch operands on start, fold one slice result per RUN cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          // Subtract is a + ~b + 1, so the slice never needs to know the op
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
              sum_d[4*i +: 4] = bus.cla_s;
            end
          end
          carry_d = bus.cla_cout;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            c_out_d = bus.cla_cout;
            // a^b^s at the MSB recovers the carry into the MSB
            ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ bus.cla_s[3] ^ bus.cla_cout;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.cla_a   = (state_q == RUN) ? nib_a   : 4'd0;
  assign bus.cla_b   = (state_q == RUN) ? nib_b   : 4'd0;
  assign bus.cla_cin = (state_q == RUN) ? carry_q : 1'b0;
  assign bus.sum     = sum_q;
  assign bus.c_out   = c_out_q;
  assign bus.ovf     = ovf_q;

endmodule
